dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer placed in front of the 256 x 8-bit data memory. It shares the single memory port between the core load/store unit (port 0) and the debug/DMA port (port 1). It also runs a bulk-clear sequence that zeroes the whole memory at runtime without a global reset. It drives the memory's we/addr/data_in and routes the memory's registered data_out back to whichever requester issued the read.

Parameters:
AW, 8, address width; memory depth is 2**AW.
DW, 8, data width.
MAX_WAIT, 4, number of consecutive denied cycles after which port 1 is force-granted under fixed priority; range 1..15.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
p0_req  input  1  port 0 access request, level; held until granted.
p0_we  input  1  port 0 write (1) or read (0).
p0_addr  input  AW  port 0 address.
p0_wdata  input  DW  port 0 write data.
p0_gnt  output  1  port 0 granted this cycle; combinational.
p0_rvalid  output  1  port 0 read data valid.
p0_rdata  output  DW  port 0 read data.
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  same as port 0, for port 1.
clr_start  input  1  single-cycle pulse that requests a bulk clear.
busy  output  1  clear sequence in progress.
clr_done  output  1  one-cycle pulse when the clear completes.
mem_we  output  1  memory write enable.
mem_addr  output  AW  memory address.
mem_wdata  output  DW  memory write data.
mem_rdata  input  DW  memory data_out; registered, valid one cycle after the address.

Behaviour:
- Reset:
  - State goes to IDLE; clear counter, wait counter, RR pointer and both rvalid flags go to 0.
  - While reset is high, gnt, rvalid, busy, clr_done and mem_we are all 0.
- FSM states: IDLE, CLEAR.
- IDLE, grant selection (combinational from req and registered state):
  - If only one port requests, that port is granted.
  - If both request, port 0 wins, unless wait_cnt == MAX_WAIT, in which case port 1 wins.
  - At most one gnt is high in any cycle.
- Memory drive in the grant cycle:
  - mem_addr/mem_we/mem_wdata take the granted port's addr/we/wdata.
  - With no grant: mem_we=0 and mem_addr holds its last value, so it has no side effects.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, when p1_req is high and p1 is not granted.
  - Clears when p1 is granted or p1_req is low.
- Read latency:
  - A read granted in cycle N gives px_rvalid=1 in cycle N+1, with px_rdata = mem_rdata.
  - Grant-to-data latency is exactly 1 cycle. Back-to-back reads give one result per cycle.
  - A write gives no rvalid.
  - px_rdata is don't-care when rvalid=0; the bench checks it only under rvalid.
- Same-address write then read: a read granted in N+1 after a write in N returns the new data.
- clr_start in IDLE:
  - The grant decision in that cycle still proceeds, and that access completes normally.
  - Next cycle the FSM enters CLEAR and busy goes high.
- CLEAR:
  - mem_we=1, mem_wdata=0, mem_addr=clr_cnt; clr_cnt counts 0..2**AW-1, one address per cycle (256 cycles by default).
  - Both gnt outputs are 0, so requests stall.
  - An rvalid pending from the last IDLE read is still delivered in the first CLEAR cycle.
  - After the last address: return to IDLE, clr_done pulses for 1 cycle in the first IDLE cycle, clr_cnt goes to 0.
- clr_start received while in CLEAR is ignored; it is neither queued nor restarts the sequence.
- Reset mid-CLEAR aborts the sequence immediately and does not pulse clr_done. Memory contents are the memory block's own responsibility.

Optional Feature:
Macro DMEM_ARB_RR_EN.
- Defined: round-robin when both ports request. A registered last-grant pointer gives priority to the port not granted most recently; the pointer updates on every grant and resets to 0, so port 0 wins the first tie. wait_cnt and MAX_WAIT are unused, and no port waits more than 1 cycle.
- Undefined: fixed priority to port 0 with the MAX_WAIT starvation guard, as above.

Test Plan:
- Reset then p0 write addr 0x10 data 0xA5, then p0 read 0x10 -> p0_gnt in the same cycle as req; p0_rvalid one cycle after the read grant with p0_rdata=0xA5; p1_rvalid stays 0.
- p0 and p1 both requesting reads every cycle (fixed priority, MAX_WAIT=4) -> p0 granted 4 cycles, p1 granted on the 5th, pattern repeats; never both gnt high.
- Same stimulus with DMEM_ARB_RR_EN defined -> grants alternate p0, p1, p0, p1...; each rvalid lands on the matching port one cycle after its grant.
- Write 0xFF to 0x00 and 0xFF; pulse clr_start; hold p0_req -> busy for 256 cycles, p0_gnt=0 throughout, clr_done pulses once; then p0 reads 0x00 and 0xFF -> 0x00 both.
- Read granted in the cycle clr_start pulses -> its rvalid still asserted next cycle with correct data; second clr_start mid-CLEAR -> no extra clr_done, busy length unchanged.
- Assert reset at clr_cnt=100 -> busy=0, clr_done never pulses; after release p1 write/read to 0x20 -> data returned correctly.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single port of a 256 x 8 data memory between the core
//            load/store unit (port 0) and the debug/DMA port (port 1). It also
//            runs a runtime bulk-clear that zeroes every address.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clk, reset            - clock, asynchronous active-high reset
//            pX_req/we/addr/wdata  - requester X access (level request)
//            pX_gnt                - combinational grant for requester X
//            pX_rvalid/rdata       - read data for X, one cycle after grant
//            clr_start             - pulse: start a bulk clear (IDLE only)
//            busy / clr_done       - clear in progress / one-cycle completion
//            mem_we/addr/wdata     - memory write port drive
//            mem_rdata             - registered memory read data
// Options  : DMEM_ARB_RR_EN        - round-robin tie-break instead of fixed
//                                    port-0 priority with a starvation guard
// ============================================================================
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    input  logic          clr_start,
    output logic          busy,
    output logic          clr_done,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] r_last_addr;
    logic          r_p0_rvalid;
    logic          r_p1_rvalid;
    logic          r_clr_done;
    logic          w_idle;
    logic          w_clear;
    logic          w_clr_last;
    logic          w_p1_wins;

    // Grants and memory writes are gated by reset so nothing leaks out while
    // reset is held, even though the grant path is purely combinational.
    assign w_idle     = (r_state == S_IDLE)  && !reset;
    assign w_clear    = (r_state == S_CLEAR) && !reset;
    assign w_clr_last = (r_clr_cnt == {AW{1'b1}});

`ifdef DMEM_ARB_RR_EN
    // Pointer names the port that wins the next tie; it flips to the other
    // port on every grant, so each tie goes to the least recently served.
    logic r_rr_ptr;

    assign w_p1_wins = r_rr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (p0_gnt) begin
            r_rr_ptr <= 1'b1;
        end else if (p1_gnt) begin
            r_rr_ptr <= 1'b0;
        end
    end
`else
    // Consecutive cycles port 1 has been refused; reaching the limit forces
    // the next tie to port 1 so it cannot starve behind port 0.
    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);
    logic [3:0] r_wait_cnt;

    assign w_p1_wins = (r_wait_cnt == c_max_wait);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
        end else if (p1_req && !p1_gnt) begin
            if (r_wait_cnt != c_max_wait) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end else begin
            r_wait_cnt <= 4'd0;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clr_start during CLEAR is simply not looked at.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr_start)  w_state_nxt = S_CLEAR;
            S_CLEAR: if (w_clr_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: grants and memory drive
    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_last_addr;
        mem_wdata = '0;
        if (w_clear) begin
            mem_we    = 1'b1;
            mem_addr  = r_clr_cnt;
        end else if (w_idle) begin
            p0_gnt = p0_req && !(p1_req && w_p1_wins);
            p1_gnt = p1_req && !p0_gnt;
            if (p0_gnt) begin
                mem_we    = p0_we;
                mem_addr  = p0_addr;
                mem_wdata = p0_wdata;
            end else if (p1_gnt) begin
                mem_we    = p1_we;
                mem_addr  = p1_addr;
                mem_wdata = p1_wdata;
            end
        end
    end

    // Clear counter, completion pulse, read-valid tracking, held address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr_cnt   <= '0;
            r_clr_done  <= 1'b0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_last_addr <= '0;
        end else begin
            r_clr_done  <= (r_state == S_CLEAR) && w_clr_last;
            r_p0_rvalid <= p0_gnt && !p0_we;
            r_p1_rvalid <= p1_gnt && !p1_we;
            r_last_addr <= mem_addr;
            if (r_state == S_CLEAR) begin
                r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
            end
        end
    end

    // Memory output is already registered, so the data lines up with the
    // one-cycle-late valid flag without further staging.
    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;
    assign busy      = (r_state == S_CLEAR);
    assign clr_done  = r_clr_done;

endmodule
`default_nettype wire
